// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit patterns (gfedcba), decoder state
// and decoded-result types, plus the pattern-to-digit decode helper.
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int SAMPLE_W = SEG_W + 1;
    localparam int DIGITS  = 8;

    // Index i holds the segment pattern that lights digit i; the encoder uses this same table.
    localparam logic [SEG_W-1:0] DIGIT_PATTERNS [DIGITS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
    };

    typedef enum logic [0:0] {
        TRACK = 1'b0,
        VALID = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] index;
        logic [7:0] onehot;
        logic       empty;
        logic       error;
    } decode_t;

    // Sample layout is {none, segs}; anything not a digit or a clean None is an error.
    function automatic decode_t decode_sample(input logic [SAMPLE_W-1:0] sample);
        decode_t res;
        res.index  = 3'd0;
        res.onehot = 8'h00;
        res.empty  = 1'b0;
        res.error  = 1'b1;
        if (sample[SAMPLE_W-1]) begin
            if (sample[SEG_W-1:0] == '0) begin
                res.empty = 1'b1;
                res.error = 1'b0;
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sample[SEG_W-1:0] == DIGIT_PATTERNS[i]) begin
                    res.index  = 3'(i);
                    res.onehot = 8'h01 << i;
                    res.error  = 1'b0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_input_filter.sv
// Two-flop synchronizer followed by a stability debouncer; 'stable' is high
// once the sample has been unchanged for STABLE_CYCLES consecutive cycles.
module seg7_input_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                stable
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SAMPLE_W-1:0] sync1_q, sync1_d;
    logic [SAMPLE_W-1:0] sync2_q, sync2_d;
    logic [SAMPLE_W-1:0] prev_q,  prev_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    always_comb begin
        sync1_d = sample_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (sync2_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sample_out = prev_q;
    assign stable     = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg7_priority_decoder.sv
// Seven-segment readback decoder: filters the pin sample, decodes it and
// reports each new stable value once over valid/ready. Define ERR_CNT_EN for err_count.
//
// state | meaning
// TRACK | waiting for a stable sample that differs from the last one reported
// VALID | result held on the outputs until out_ready
module seg7_priority_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] seg_in,
    input  logic             none_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       out_index,
    output logic [7:0]       out_onehot,
    output logic             out_empty,
    output logic             out_error
`ifdef ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    logic [SAMPLE_W-1:0] sample;
    logic                stable;
    decode_t             dec;

    state_e              state_q,         state_d;
    logic [2:0]          out_index_q,     out_index_d;
    logic [7:0]          out_onehot_q,    out_onehot_d;
    logic                out_empty_q,     out_empty_d;
    logic                out_error_q,     out_error_d;
    logic [SAMPLE_W-1:0] last_reported_q, last_reported_d;
    logic                load;

    seg7_input_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .sample_in  ({none_in, seg_in}),
        .sample_out (sample),
        .stable     (stable)
    );

    always_comb begin
        dec             = decode_sample(sample);
        state_d         = state_q;
        out_index_d     = out_index_q;
        out_onehot_d    = out_onehot_q;
        out_empty_d     = out_empty_q;
        out_error_d     = out_error_q;
        last_reported_d = last_reported_q;
        load            = 1'b0;
        case (state_q)
            TRACK: begin
                // last_reported resets to 8'h00, so an all-dark bus is never reported after reset.
                if (stable && (sample != last_reported_q)) begin
                    load            = 1'b1;
                    out_index_d     = dec.index;
                    out_onehot_d    = dec.onehot;
                    out_empty_d     = dec.empty;
                    out_error_d     = dec.error;
                    last_reported_d = sample;
                    state_d         = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    state_d = TRACK;
                end
            end
            default: begin
                state_d = TRACK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= TRACK;
            out_index_q     <= '0;
            out_onehot_q    <= '0;
            out_empty_q     <= 1'b0;
            out_error_q     <= 1'b0;
            last_reported_q <= '0;
        end else begin
            state_q         <= state_d;
            out_index_q     <= out_index_d;
            out_onehot_q    <= out_onehot_d;
            out_empty_q     <= out_empty_d;
            out_error_q     <= out_error_d;
            last_reported_q <= last_reported_d;
        end
    end

`ifdef ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (load && dec.error && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign out_valid  = (state_q == VALID);
    assign out_index  = out_index_q;
    assign out_onehot = out_onehot_q;
    assign out_empty  = out_empty_q;
    assign out_error  = out_error_q;

endmodule

// File: doc/seg7_priority_decoder.md
Name: seg7_priority_decoder

Overview:
- Inverse of the 8-bit priority encoder with 7-segment output: receives the 7-segment code (segments abcdefg) and the None pin, and recovers the 3-bit index and an 8-bit one-hot vector.
- Inputs come from external pins, so they are synchronized and debounced before decoding.
- Each new stable value is presented once on a valid/ready output interface; used as the readback and loopback checker for the encoder.

Parameters:
- STABLE_CYCLES, 4, consecutive unchanged synchronized cycles required before a sample is accepted; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_in  input  7  segment code, bit6=g .. bit0=a, asynchronous
- none_in  input  1  None/decimal-point pin, asynchronous
- out_ready  input  1  consumer accepts the result
- out_valid  output  1  result available
- out_index  output  3  decoded digit 0..7
- out_onehot  output  8  1<<out_index when valid digit, else 0
- out_empty  output  1  sample was None=1 with all segments off
- out_error  output  1  sample matches no legal code
- err_count  output  8  only with ERR_CNT_EN, see below

Behaviour:
- Reset (clk edge with rst=1): all registers 0; out_valid=0, out_index=0, out_onehot=0, out_empty=0, out_error=0; state TRACK; last_reported=8'h00.
- Input pipeline on the sample {none_in, seg_in}, 8 bits:
  - sync1 -> sync2: 2 flops.
  - prev <= sync2.
  - Stability counter cnt, width clog2(STABLE_CYCLES+1): cnt <= 0 when sync2 != prev, else cnt <= cnt+1, saturating at STABLE_CYCLES.
  - stable = (cnt == STABLE_CYCLES).
- Decode of prev, combinational:
  - none=0 and segs equal to a digit pattern: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07 (hex, gfedcba). Result: index, onehot=1<<index, empty=0, error=0.
  - none=1 and segs=0: index=0, onehot=0, empty=1, error=0.
  - Anything else: index=0, onehot=0, empty=0, error=1.
- FSM:
  - TRACK: if stable and prev != last_reported, load the decoded fields into the output registers, last_reported <= prev, go to VALID.
  - VALID: out_valid=1; outputs are frozen. If out_ready=1, go to TRACK; out_valid is low from the next edge.
- Latency: an input held constant from edge 0 gives out_valid high after edge STABLE_CYCLES+4 (8 with the default), provided the FSM is in TRACK.
- The sync, prev and cnt logic keeps running in VALID. A value that stabilizes during VALID is emitted on the second edge after the handshake. Intermediate stable values overwritten during VALID are dropped; only the latest stable value is reported.
- A repeated identical stable value is never re-emitted. The all-dark pattern 8'h00 after reset is never emitted; it is error-class, but it matches the reset value of last_reported.
- Any pattern change shorter than STABLE_CYCLES cycles produces no output.
- rst mid-VALID: out_valid=0 at the next edge, last_reported cleared, and the current pin value is re-reported once it is stable.

Optional Feature:
- Macro ERR_CNT_EN.
- Defined: port err_count exists. It is an 8-bit saturating counter (max 255) incremented on each TRACK->VALID load with error=1, and cleared by rst.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package seg7_pkg holds:
  - SEG_W=7
  - the 8-entry digit pattern constant array (gfedcba)
  - the state enum {TRACK, VALID}
  - the decoded-result struct (index, onehot, empty, error)
- The encoder side reuses the same digit array.
- Sub-module seg7_input_filter contains sync1, sync2, prev, cnt and the stable output, parameterized by STABLE_CYCLES. The top level holds the decode, FSM and output registers.

Test Plan:
- Reset, then seg_in=00, none_in=0 held for 50 cycles -> out_valid never asserts; all outputs stay 0.
- seg_in=5B, none_in=0 held, out_ready=1 -> out_valid=1 exactly at edge 8, out_index=2, out_onehot=04, one-cycle pulse, no repeat.
- seg_in=07 for 2 cycles then back to the previous stable value -> no out_valid. Then 07 held for 10 cycles -> out_index=7, out_onehot=80.
- out_ready=0, seg_in=7D -> out_valid held with index 6. Change to 4F for 20 cycles -> outputs stay 6. Pulse out_ready -> valid drops, then index=3 is emitted 2 edges after the handshake.
- none_in=1, seg_in=00 -> out_empty=1, out_onehot=00. Then seg_in=7F, none_in=0 -> out_error=1, and with ERR_CNT_EN err_count=1.
- Assert rst while out_valid=1 with index 5 (6D held) -> out_valid=0 next edge. After releasing rst, 6D is re-reported STABLE_CYCLES+4 edges later.
